display_scanner: RTL and testbench

Time-multiplexing scanner for the 4-digit seven-segment display. Holds a 16-bit hex value, steps a 2-bit digit index at a fixed refresh rate, and presents the current digit index and its nibble to the downstream decoders. The digit index drives the anode decoder's `switch_in`, and the nibble drives the cathode/segment decoder. New values are double-buffered and committed only at frame boundaries, so a digit never shows a partially updated value.

---
 rtl/display_pkg.sv | 17 +
 rtl/refresh_prescaler.sv | 33 +++
 rtl/display_scanner.sv | 94 +++++++++
 tb/tb_display_scanner.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared definitions for the seven-segment display path
// (scanner, anode decoder, segment decoder).
//   NUM_DIGITS  - digits on the display
//   DIGIT_W     - width of a digit index
//   NIBBLE_W    - width of one hex digit
//   digit_idx_t - digit index type (anode decoder switch_in)
//   nibble_t    - hex digit type (segment decoder input)
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 2;
  localparam int unsigned NIBBLE_W   = 4;

  typedef logic [DIGIT_W-1:0]  digit_idx_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/refresh_prescaler.sv
// refresh_prescaler: free-running modulo-REFRESH_DIV counter.
//   REFRESH_DIV - cycles per tick period (>= 2)
//   clk         - system clock
//   reset       - synchronous active-high reset, counter returns to 0
//   tick        - high during the last cycle of each period (count == REFRESH_DIV-1)
module refresh_prescaler #(
  parameter int unsigned REFRESH_DIV = 100_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexing scanner for a 4-digit seven-segment display.
// Holds a double-buffered 16-bit hex value and steps the active digit every
// REFRESH_DIV cycles. New values are committed only at frame boundaries.
//   REFRESH_DIV - cycles each digit is held (>= 2)
//   clk         - system clock
//   reset       - synchronous active-high reset
//   value_in    - value to display, digit k = value_in[4k+3:4k]
//   load        - capture value_in into the pending buffer (last one wins)
//   load_ack    - one-cycle pulse when the pending value becomes displayed
//   digit_sel   - active digit index (anode decoder)
//   nibble      - hex value of the active digit (segment decoder)
//   blank       - active digit must be dark
//   frame_start - first cycle of each digit-0 dwell
// Build option: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never).
module display_scanner
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         value_in,
  input  logic                load,
  output logic                load_ack,
  output digit_idx_t          digit_sel,
  output nibble_t             nibble,
  output logic                blank,
  output logic                frame_start
);

  logic        tick;
  logic        commit;

  digit_idx_t  digit_sel_q,   digit_sel_d;
  logic [15:0] active_q,      active_d;
  logic [15:0] pending_q,     pending_d;
  logic        pending_v_q,   pending_v_d;
  logic        load_ack_q,    load_ack_d;
  logic        frame_start_q, frame_start_d;

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    commit        = tick && (digit_sel_q == digit_idx_t'(NUM_DIGITS - 1)) && pending_v_q;
    digit_sel_d   = tick ? digit_sel_q + digit_idx_t'(1) : digit_sel_q;
    active_d      = commit ? pending_q : active_q;
    pending_d     = load ? value_in : pending_q;
    // A load in the commit cycle re-arms the buffer for the next frame.
    pending_v_d   = load | (pending_v_q & ~commit);
    load_ack_d    = commit;
    // Registered form of (digit_sel == 0 && cnt == 0): the cycle after the
    // last tick of digit 3, so the prescaler count need not be exported.
    frame_start_d = tick && (digit_sel_q == digit_idx_t'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_sel_q   <= '0;
      active_q      <= '0;
      pending_q     <= '0;
      pending_v_q   <= 1'b0;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b1;
    end else begin
      digit_sel_q   <= digit_sel_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      pending_v_q   <= pending_v_d;
      load_ack_q    <= load_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    digit_sel   = digit_sel_q;
    load_ack    = load_ack_q;
    frame_start = frame_start_q;
    nibble      = nibble_t'(active_q >> {digit_sel_q, 2'b00});
`ifdef LEADING_ZERO_BLANK_EN
    // Shifting out the lower digits leaves zero exactly when this digit and
    // every more significant one are zero.
    blank       = (digit_sel_q != '0) && ((active_q >> {digit_sel_q, 2'b00}) == '0);
`else
    blank       = 1'b0;
`endif
  end

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic        load;
  logic        load_ack;
  logic [1:0]  digit_sel;
  logic [3:0]  nibble;
  logic        blank;
  logic        frame_start;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned dut_acks = 0;

  // Reference model: state expressed as cycles since reset plus the two buffers.
  int unsigned k = 0;
  logic [15:0] m_act = '0;
  logic [15:0] m_pend = '0;
  logic        m_pv = 1'b0;
  logic        m_ack = 1'b0;

  display_scanner #(.REFRESH_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .load        (load),
    .load_ack    (load_ack),
    .digit_sel   (digit_sel),
    .nibble      (nibble),
    .blank       (blank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d, t=%0t)", name, act, exp, k, $time);
    end
  endtask

  function automatic int unsigned exp_blank(input int unsigned d, input logic [15:0] a);
`ifdef LEADING_ZERO_BLANK_EN
    return (d != 0 && (a >> (4 * d)) == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // One clock: apply inputs, advance the model on the edge, compare all outputs.
  task automatic step(input logic l, input logic [15:0] v, input logic r);
    int unsigned d;
    load = l;
    value_in = v;
    reset = r;
    @(posedge clk);
    if (r) begin
      k = 0; m_act = '0; m_pend = '0; m_pv = 1'b0; m_ack = 1'b0;
    end else begin
      m_ack = (k % 16 == 15) && m_pv;
      if (m_ack) begin
        m_act = m_pend;
        m_pv = 1'b0;
      end
      if (l) begin
        m_pend = v;
        m_pv = 1'b1;
      end
      k++;
    end
    #1;
    d = (k / 4) % 4;
    check("digit_sel",   digit_sel,   d);
    check("frame_start", frame_start, (k % 16 == 0) ? 1 : 0);
    check("nibble",      nibble,      (m_act >> (4 * d)) & 16'hF);
    check("load_ack",    load_ack,    m_ack);
    check("blank",       blank,       exp_blank(d, m_act));
    if (load_ack) dut_acks++;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic idle_until(input int unsigned phase);
    for (int unsigned i = 0; i < 16 && (k % 16) != phase; i++) step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic wait_ack();
    bit seen = 0;
    for (int unsigned i = 0; i < 80 && !seen; i++) begin
      step(1'b0, 16'h0, 1'b0);
      seen = load_ack;
    end
    if (!seen) check("ack_timeout", 0, 1);
  endtask

  initial begin
    int unsigned a0;
    int unsigned exp_bl [4];
    logic [3:0] nib_exp [4];

    load = 1'b0; value_in = '0; reset = 1'b1;
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    check("rst_frame_start_lit", frame_start, 1);
    check("rst_nibble_lit", nibble, 0);

    // Reset release: digit sequence and frame_start positions.
    for (int unsigned i = 1; i <= 17; i++) begin
      step(1'b0, 16'h0, 1'b0);
      check("scan_digit_lit", digit_sel, (i / 4) % 4);
      check("scan_fs_lit", frame_start, (i == 16) ? 1 : 0);
    end

    // Single load mid-frame.
    idle_until(5);
    step(1'b1, 16'h1234, 1'b0);
    wait_ack();
    nib_exp[0] = 4'h4; nib_exp[1] = 4'h3; nib_exp[2] = 4'h2; nib_exp[3] = 4'h1;
    for (int unsigned d = 0; d < 4; d++) begin
      check("n1234_lit", nibble, nib_exp[d]);
      check("n1234_fs_lit", frame_start, (d == 0) ? 1 : 0);
      idle(4);
    end

    // Two loads in one frame: last wins, one ack.
    a0 = dut_acks;
    idle_until(2);
    step(1'b1, 16'hAAAA, 1'b0);
    idle_until(7);
    step(1'b1, 16'hBBBB, 1'b0);
    wait_ack();
    check("nBBBB_lit", nibble, 4'hB);
    idle(20);
    check("one_ack_lit", dut_acks - a0, 1);

    // Load on the commit cycle while another value is pending.
    a0 = dut_acks;
    idle_until(10);
    step(1'b1, 16'h1111, 1'b0);
    idle_until(15);
    step(1'b1, 16'h5555, 1'b0);
    check("n1111_lit", nibble, 4'h1);
    check("ack1_lit", load_ack, 1);
    wait_ack();
    check("n5555_lit", nibble, 4'h5);
    check("two_ack_lit", dut_acks - a0, 2);

    // Leading-zero blanking.
    idle_until(3);
    step(1'b1, 16'h00A0, 1'b0);
    wait_ack();
`ifdef LEADING_ZERO_BLANK_EN
    exp_bl[0] = 0; exp_bl[1] = 0; exp_bl[2] = 1; exp_bl[3] = 1;
`else
    exp_bl[0] = 0; exp_bl[1] = 0; exp_bl[2] = 0; exp_bl[3] = 0;
`endif
    for (int unsigned d = 0; d < 4; d++) begin
      check("blank_lit", blank, exp_bl[d]);
      check("n00A0_lit", nibble, (d == 1) ? 4'hA : 4'h0);
      idle(4);
    end

    // Reset with a pending load: discarded, no ack.
    idle_until(4);
    step(1'b1, 16'hBEEF, 1'b0);
    idle(3);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    a0 = dut_acks;
    idle(40);
    check("rst_no_ack_lit", dut_acks - a0, 0);
    check("rst_nibble0_lit", nibble, 0);

    // Randomized traffic against the model.
    for (int unsigned i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 11) == 0), 16'($urandom), ($urandom_range(0, 599) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
